// File: rtl/fc_crc32_chk.sv
// CRC-32 frame checker for a 64-bit word stream (poly 0x04C11DB7, MSB-first, no final inversion).
// Reports residue match, word count and framing errors in a one-cycle strobe after each frame.
module fc_crc32_chk #(
  parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704_DD7B,
  parameter logic [15:0] MAX_WORDS   = 16'd272
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic        IN_SOF,
  input  logic        IN_EOF,
  input  logic        IN_HALF,
  input  logic [63:0] IN_DATA,
  output logic        OUT_DONE,
  output logic        OUT_CRC_OK,
  output logic [31:0] OUT_CRC,
  output logic [15:0] OUT_WORD_CNT,
  output logic        OUT_PROTO_ERR
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  // state  | meaning
  // IDLE   | waiting for SOF; non-SOF words are orphans (unless dropping after overrun)
  // FRAME  | folding words into the CRC until EOF, SOF or MAX_WORDS
  // REPORT | result strobe; incoming words are handled as in IDLE
  typedef enum logic [1:0] {IDLE, FRAME, REPORT} state_t;

  state_t      state, state_nxt;
  logic [31:0] crc_q, crc_nxt;
  logic [15:0] cnt_q, cnt_nxt, cnt_inc;
  logic        orphan_q, orphan_nxt;
  logic        ferr_q, ferr_nxt;
  logic        drop_q, drop_nxt;
  logic        load, load_err, rep_err;
  logic        half_eof, half_bad;

  // Upper 32 bits only when half is set; bit 63 enters first.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [63:0] data,
                                           input logic half);
    logic [31:0] c;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      if (!half || i >= 32) begin
        if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ POLY;
        else                 c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  assign half_eof = IN_HALF & IN_EOF;
  assign half_bad = IN_HALF & ~IN_EOF;
  assign cnt_inc  = (cnt_q >= MAX_WORDS) ? MAX_WORDS : cnt_q + 16'd1;
  assign rep_err  = load_err | ferr_nxt | orphan_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    crc_nxt    = crc_q;
    cnt_nxt    = cnt_q;
    orphan_nxt = orphan_q;
    ferr_nxt   = ferr_q;
    drop_nxt   = drop_q;
    load       = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE, REPORT: begin
        state_nxt = IDLE;
        if (IN_VALID) begin
          if (IN_SOF) begin
            crc_nxt  = crc_fold(CRC_INIT, IN_DATA, half_eof);
            cnt_nxt  = 16'd1;
            ferr_nxt = half_bad;
            drop_nxt = 1'b0;
            if (IN_EOF) begin
              state_nxt = REPORT;
              load      = 1'b1;
            end else begin
              state_nxt = FRAME;
            end
          end else if (!drop_q) begin
            orphan_nxt = 1'b1;
          end
        end
      end
      FRAME: begin
        if (IN_VALID) begin
          if (IN_SOF) begin
            state_nxt = REPORT;
            load      = 1'b1;
            load_err  = 1'b1;
          end else begin
            crc_nxt  = crc_fold(crc_q, IN_DATA, half_eof);
            cnt_nxt  = cnt_inc;
            ferr_nxt = ferr_q | half_bad;
            if (IN_EOF) begin
              state_nxt = REPORT;
              load      = 1'b1;
            end else if (cnt_inc == MAX_WORDS) begin
              // overrun: remaining words of this frame are silently dropped
              state_nxt = REPORT;
              load      = 1'b1;
              load_err  = 1'b1;
              drop_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) orphan_nxt = 1'b0;
  end

  always_comb begin
    OUT_DONE = (state == REPORT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q         <= CRC_INIT;
      cnt_q         <= 16'h0;
      orphan_q      <= 1'b0;
      ferr_q        <= 1'b0;
      drop_q        <= 1'b0;
      OUT_CRC       <= 32'h0;
      OUT_WORD_CNT  <= 16'h0;
      OUT_CRC_OK    <= 1'b0;
      OUT_PROTO_ERR <= 1'b0;
    end else begin
      crc_q    <= crc_nxt;
      cnt_q    <= cnt_nxt;
      orphan_q <= orphan_nxt;
      ferr_q   <= ferr_nxt;
      drop_q   <= drop_nxt;
      if (load) begin
        OUT_CRC       <= crc_nxt;
        OUT_WORD_CNT  <= cnt_nxt;
        OUT_PROTO_ERR <= rep_err;
        OUT_CRC_OK    <= (crc_nxt == CRC_RESIDUE) && !rep_err;
      end
    end
  end

endmodule

// File: doc/fc_crc32_chk.md
FC_CRC32_CHK -- requirements
Module: fc_crc32_chk

Interface
REQ-001 Parameters SHALL be: CRC_INIT, default 32'hFFFF_FFFF, CRC register preload at SOF; CRC_RESIDUE, default 32'hC704_DD7B, good-frame residue; MAX_WORDS, default 16'd272, maximum 64-bit words per frame.
REQ-002 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port list:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous active-high reset.
- IN_VALID  input  1  word qualifier; no backpressure.
- IN_SOF  input  1  first word of frame, qualified by IN_VALID.
- IN_EOF  input  1  last word of frame, qualified by IN_VALID.
- IN_HALF  input  1  with IN_EOF: only IN_DATA[63:32] valid.
- IN_DATA  input  64  bit-ordered data from the upstream reverse stage; bit 63 is first on the wire.
- OUT_DONE  output  1  one-cycle result strobe.
- OUT_CRC_OK  output  1  residue match, valid with OUT_DONE.
- OUT_CRC  output  32  final raw CRC register, valid with OUT_DONE.
- OUT_WORD_CNT  output  16  accepted words in the frame, including the half word, valid with OUT_DONE.
- OUT_PROTO_ERR  output  1  framing violation, valid with OUT_DONE.

Function
REQ-004 The block SHALL compute CRC-32 with polynomial 0x04C11DB7, non-reflected and MSB-first. IN_DATA[63] SHALL be the first bit shifted in. There SHALL be no final inversion.
REQ-005 A full word SHALL advance the CRC by 64 bits in one cycle. A word with IN_EOF=1 and IN_HALF=1 SHALL advance it by IN_DATA[63:32] only.
REQ-006 The FSM SHALL have states IDLE, FRAME and REPORT. The reset state SHALL be IDLE.
REQ-007 In IDLE, IN_VALID & IN_SOF SHALL do the following:
- preload CRC_INIT and fold in the word;
- set count to 1;
- go to FRAME, or go to REPORT if IN_EOF is also set (single-word frame).
REQ-008 In IDLE, IN_VALID without IN_SOF SHALL discard the word and set a sticky orphan flag. The flag SHALL be reported on the next OUT_DONE.
REQ-009 In FRAME, IN_VALID SHALL fold the word and increment the count. IN_EOF SHALL move the FSM to REPORT.
REQ-010 In FRAME, IN_VALID & IN_SOF SHALL be handled as follows:
- terminate the current frame as a protocol error and go to REPORT;
- do not fold the new word;
- drop the new frame start.
REQ-011 In FRAME, when the count reaches MAX_WORDS without EOF, the FSM SHALL go to REPORT with OUT_PROTO_ERR=1. Remaining words SHALL be discarded until the next SOF.
REQ-012 REPORT SHALL last exactly one cycle, then return to IDLE. Any IN_VALID word during REPORT SHALL be treated under IDLE rules, so back-to-back frames are supported.
REQ-013 OUT_DONE SHALL assert in the REPORT cycle, which is 1 cycle after the terminating word is accepted.
REQ-014 OUT_CRC, OUT_WORD_CNT, OUT_CRC_OK and OUT_PROTO_ERR SHALL be registered. They SHALL hold their values until the next OUT_DONE.
REQ-015 OUT_CRC_OK SHALL equal (OUT_CRC == CRC_RESIDUE) && !OUT_PROTO_ERR.
REQ-016 OUT_PROTO_ERR SHALL be 1 for any of the following, otherwise 0:
- orphan word;
- SOF inside a frame;
- MAX_WORDS overrun;
- IN_HALF without IN_EOF (the word is treated as full).
REQ-017 IN_SOF, IN_EOF and IN_HALF SHALL be ignored when IN_VALID=0. Idle gaps inside a frame SHALL NOT alter the CRC or the count.
REQ-018 The word counter SHALL be 16 bits and SHALL saturate at MAX_WORDS. It SHALL never wrap.

Reset
REQ-019 While RST=1 the block SHALL hold the following values:
- FSM in IDLE;
- CRC register = CRC_INIT;
- counter, orphan flag, OUT_DONE, OUT_CRC_OK and OUT_PROTO_ERR = 0;
- OUT_CRC = 32'h0, OUT_WORD_CNT = 16'h0.
REQ-020 RST asserted mid-frame SHALL abort the frame with no OUT_DONE. The first word after RST deasserts SHALL be treated under IDLE rules.

Verification
REQ-021 A bench SHALL cover the following directed scenarios:
- Good frame: 4 full payload words, then one IN_HALF EOF word whose upper 32 bits are ~CRC of the payload -> OUT_DONE one cycle later; OUT_CRC=32'hC704DD7B; OUT_CRC_OK=1; OUT_WORD_CNT=5; OUT_PROTO_ERR=0.
- Same frame with bit 0 of word 2 flipped -> OUT_CRC_OK=0; OUT_CRC!=32'hC704DD7B; OUT_WORD_CNT=5.
- SOF+EOF single word 64'h0 -> OUT_DONE next cycle; OUT_WORD_CNT=1; OUT_CRC matches the reference model for init FFFF_FFFF.
- SOF on cycle 0, SOF again on cycle 3 -> OUT_DONE on cycle 4 with OUT_PROTO_ERR=1, OUT_WORD_CNT=3; the next frame's orphan EOF -> OUT_PROTO_ERR=1.
- 300 words with no EOF and MAX_WORDS=272 -> OUT_DONE one cycle after word 272; OUT_WORD_CNT=272; OUT_PROTO_ERR=1; words 273-300 discarded.
- RST pulse after word 2 of a frame, then a good frame -> no OUT_DONE for the aborted frame; the good frame reports OUT_CRC_OK=1.
